// File: rtl/id_ex_if.sv
// id_ex_if: bundle of ID-side inputs, MEM/WB forwarding sources and EX-side outputs
// for the id_ex_stage pipeline register.
`default_nettype none

interface id_ex_if;
    logic        id_valid;
    logic        id_rf_we;
    logic        id_ram_we;
    logic        id_alub_sel;
    logic [1:0]  id_wd_sel;
    logic [2:0]  id_alu_op;
    logic [2:0]  id_br_op;
    logic [31:0] id_pc;
    logic [31:0] id_rD1;
    logic [31:0] id_rD2;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        mem_rf_we;
    logic        wb_rf_we;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic [31:0] mem_wd;
    logic [31:0] wb_wd;
    logic        hold;
    logic        flush;
    logic        stall;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_pc;
    logic [2:0]  ex_alu_op;
    logic [2:0]  ex_br_op;
    logic        ex_valid;
    logic        ex_rf_we;
    logic        ex_ram_we;
    logic [1:0]  ex_wd_sel;
    logic [4:0]  ex_rd;

    modport master (
        output id_valid, id_rf_we, id_ram_we, id_alub_sel, id_wd_sel, id_alu_op, id_br_op,
               id_pc, id_rD1, id_rD2, id_imm, id_rs1, id_rs2, id_rd,
               mem_rf_we, wb_rf_we, mem_rd, wb_rd, mem_wd, wb_wd, hold, flush,
        input  stall, ex_A, ex_B, ex_rs2_data, ex_pc, ex_alu_op, ex_br_op,
               ex_valid, ex_rf_we, ex_ram_we, ex_wd_sel, ex_rd
    );

    modport slave (
        input  id_valid, id_rf_we, id_ram_we, id_alub_sel, id_wd_sel, id_alu_op, id_br_op,
               id_pc, id_rD1, id_rD2, id_imm, id_rs1, id_rs2, id_rd,
               mem_rf_we, wb_rf_we, mem_rd, wb_rd, mem_wd, wb_wd, hold, flush,
        output stall, ex_A, ex_B, ex_rs2_data, ex_pc, ex_alu_op, ex_br_op,
               ex_valid, ex_rf_we, ex_ram_we, ex_wd_sel, ex_rd
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding and
// load-use stall detection. Forwarding is enabled by macro ID_EX_FORWARD_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic rst,
    id_ex_if.slave    bus
);
    localparam logic [1:0] c_WD_LOAD = 2'b01;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic        ram_we;
        logic        alub_sel;
        logic [1:0]  wd_sel;
        logic [2:0]  alu_op;
        logic [2:0]  br_op;
        logic [31:0] pc;
        logic [31:0] rD1;
        logic [31:0] rD2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_regs_t;

    ex_regs_t    r_ex;
    ex_regs_t    w_id;
    logic        w_hazard;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    always_comb begin
        w_id          = '0;
        w_id.valid    = bus.id_valid;
        w_id.rf_we    = bus.id_rf_we;
        w_id.ram_we   = bus.id_ram_we;
        w_id.alub_sel = bus.id_alub_sel;
        w_id.wd_sel   = bus.id_wd_sel;
        w_id.alu_op   = bus.id_alu_op;
        w_id.br_op    = bus.id_br_op;
        w_id.pc       = bus.id_pc;
        w_id.rD1      = bus.id_rD1;
        w_id.rD2      = bus.id_rD2;
        w_id.imm      = bus.id_imm;
        w_id.rs1      = bus.id_rs1;
        w_id.rs2      = bus.id_rs2;
        w_id.rd       = bus.id_rd;
    end

    // A bubble is all-zero: BR_NONE and x0 destination both encode as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex    <= '0;
            r_ex.pc <= RESET_PC;
        end else if (bus.flush) begin
            r_ex <= '0;
        end else if (!bus.hold) begin
            if (w_hazard) r_ex <= '0;
            else          r_ex <= w_id;
        end
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        w_hazard = r_ex.valid && (r_ex.wd_sel == c_WD_LOAD) && (r_ex.rd != 5'd0) &&
                   ((r_ex.rd == bus.id_rs1) || (r_ex.rd == bus.id_rs2)) && bus.id_valid;
    end

    // MEM wins over WB because it holds the younger result.
    always_comb begin
        w_op1 = r_ex.rD1;
        if (bus.mem_rf_we && (bus.mem_rd != 5'd0) && (bus.mem_rd == r_ex.rs1))
            w_op1 = bus.mem_wd;
        else if (bus.wb_rf_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == r_ex.rs1))
            w_op1 = bus.wb_wd;
        w_op2 = r_ex.rD2;
        if (bus.mem_rf_we && (bus.mem_rd != 5'd0) && (bus.mem_rd == r_ex.rs2))
            w_op2 = bus.mem_wd;
        else if (bus.wb_rf_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == r_ex.rs2))
            w_op2 = bus.wb_wd;
    end
`else
    logic w_hit1;
    logic w_hit2;
    logic w_unused;

    // Without bypassing, any in-flight writer of a source register blocks issue.
    always_comb begin
        w_hit1 = (bus.id_rs1 != 5'd0) &&
                 ((r_ex.rf_we   && (r_ex.rd    == bus.id_rs1)) ||
                  (bus.mem_rf_we && (bus.mem_rd == bus.id_rs1)) ||
                  (bus.wb_rf_we  && (bus.wb_rd  == bus.id_rs1)));
        w_hit2 = (bus.id_rs2 != 5'd0) &&
                 ((r_ex.rf_we   && (r_ex.rd    == bus.id_rs2)) ||
                  (bus.mem_rf_we && (bus.mem_rd == bus.id_rs2)) ||
                  (bus.wb_rf_we  && (bus.wb_rd  == bus.id_rs2)));
        w_hazard = bus.id_valid && (w_hit1 || w_hit2);
        w_op1    = r_ex.rD1;
        w_op2    = r_ex.rD2;
        w_unused = ^{bus.mem_wd, bus.wb_wd, r_ex.rs1, r_ex.rs2};
    end
`endif

    assign bus.stall       = w_hazard && !rst;
    assign bus.ex_A        = w_op1;
    assign bus.ex_rs2_data = w_op2;
    assign bus.ex_B        = r_ex.alub_sel ? r_ex.imm : w_op2;
    assign bus.ex_pc       = r_ex.pc;
    assign bus.ex_alu_op   = r_ex.alu_op;
    assign bus.ex_br_op    = r_ex.br_op;
    assign bus.ex_valid    = r_ex.valid;
    assign bus.ex_rf_we    = r_ex.rf_we;
    assign bus.ex_ram_we   = r_ex.ram_we;
    assign bus.ex_wd_sel   = r_ex.wd_sel;
    assign bus.ex_rd       = r_ex.rd;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage; covers reset, flush,
// hold, operand selection and the hazard/forwarding behaviour of the built mode.
`default_nettype none

module tb_id_ex_stage;
    localparam logic [31:0] c_RST_PC = 32'h0000_1000;

    typedef struct {
        string        tag;
        logic [144:0] v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];
    logic [144:0] obs;

    id_ex_if bus ();

    id_ex_stage #(.RESET_PC(c_RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.stall, bus.ex_valid, bus.ex_rf_we, bus.ex_ram_we, bus.ex_wd_sel,
                  bus.ex_rd, bus.ex_alu_op, bus.ex_br_op, bus.ex_pc,
                  bus.ex_A, bus.ex_B, bus.ex_rs2_data};

    function automatic logic [144:0] pk(input logic st, input logic v, input logic we,
                                        input logic rwe, input logic [1:0] ws,
                                        input logic [4:0] rd, input logic [2:0] alu,
                                        input logic [2:0] br, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] r2);
        return {st, v, we, rwe, ws, rd, alu, br, pc, a, b, r2};
    endfunction

    task automatic push(input string tag, input logic [144:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed=%h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed=%h required=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic set_id(input logic v, input logic we, input logic rwe, input logic bs,
                          input logic [1:0] ws, input logic [2:0] alu, input logic [2:0] br,
                          input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] rd);
        bus.id_valid = v;   bus.id_rf_we = we;  bus.id_ram_we = rwe; bus.id_alub_sel = bs;
        bus.id_wd_sel = ws; bus.id_alu_op = alu; bus.id_br_op = br;  bus.id_pc = pc;
        bus.id_rD1 = d1;    bus.id_rD2 = d2;    bus.id_imm = imm;
        bus.id_rs1 = s1;    bus.id_rs2 = s2;    bus.id_rd = rd;
    endtask

    task automatic set_fw(input logic mwe, input logic [4:0] mrd, input logic [31:0] mwd,
                          input logic wwe, input logic [4:0] wrd, input logic [31:0] wwd);
        bus.mem_rf_we = mwe; bus.mem_rd = mrd; bus.mem_wd = mwd;
        bus.wb_rf_we  = wwe; bus.wb_rd  = wrd; bus.wb_wd  = wwd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        push("reset", pk(0, 0, 0, 0, 2'b00, 0, 0, 0, c_RST_PC, 0, 0, 0));
        check();
        rst = 1'b0;

        // b: immediate operand selected for B
        set_id(1, 1, 0, 1, 2'b00, 3'd2, 3'd0, 32'h100, 32'hAAAA, 32'hBBBB, 32'h10, 5'd1, 5'd2, 5'd4);
        push("latch_b", pk(0, 1, 1, 0, 2'b00, 5'd4, 3'd2, 3'd0, 32'h100, 32'hAAAA, 32'h10, 32'hBBBB));
        tick(); check();

        rst = 1'b1; #1;
        push("async_reset", pk(0, 0, 0, 0, 2'b00, 0, 0, 0, c_RST_PC, 0, 0, 0));
        check();
        tick(); rst = 1'b0;

        push("relatch_b", pk(0, 1, 1, 0, 2'b00, 5'd4, 3'd2, 3'd0, 32'h100, 32'hAAAA, 32'h10, 32'hBBBB));
        tick(); check();
        bus.flush = 1'b1; bus.hold = 1'b1;
        push("flush_over_hold", pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tick(); check();
        bus.flush = 1'b0; bus.hold = 1'b0;

        // e: register operand for B
        set_id(1, 1, 0, 0, 2'b00, 3'd7, 3'd3, 32'h104, 32'hE1, 32'hE2, 32'h5, 5'd13, 5'd14, 5'd12);
        push("latch_e", pk(0, 1, 1, 0, 2'b00, 5'd12, 3'd7, 3'd3, 32'h104, 32'hE1, 32'hE2, 32'hE2));
        tick(); check();
        bus.hold = 1'b1;
        set_id(1, 1, 1, 0, 2'b10, 3'd1, 3'd5, 32'h108, 32'hF1, 32'hF2, 32'h20, 5'd15, 5'd16, 5'd4);
        push("hold_keeps", pk(0, 1, 1, 0, 2'b00, 5'd12, 3'd7, 3'd3, 32'h104, 32'hE1, 32'hE2, 32'hE2));
        tick(); check();
        bus.hold = 1'b0;
        push("latch_f", pk(0, 1, 1, 1, 2'b10, 5'd4, 3'd1, 3'd5, 32'h108, 32'hF1, 32'hF2, 32'hF2));
        tick(); check();

`ifdef ID_EX_FORWARD_EN
        set_id(1, 1, 0, 0, 2'b00, 3'd0, 3'd0, 32'h10C, 32'h11, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6);
        push("latch_g", pk(0, 1, 1, 0, 2'b00, 5'd6, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        tick(); check();
        bus.id_valid = 1'b0;
        set_fw(1, 5'd5, 32'h1234, 0, 0, 0); #1;
        push("fwd_mem", pk(0, 1, 1, 0, 2'b00, 5'd6, 0, 0, 32'h10C, 32'h1234, 32'h0, 32'h0));
        check();
        set_fw(1, 5'd5, 32'h1234, 1, 5'd5, 32'h9); #1;
        push("fwd_mem_over_wb", pk(0, 1, 1, 0, 2'b00, 5'd6, 0, 0, 32'h10C, 32'h1234, 32'h0, 32'h0));
        check();
        set_fw(0, 5'd5, 32'h1234, 1, 5'd5, 32'h9); #1;
        push("fwd_wb", pk(0, 1, 1, 0, 2'b00, 5'd6, 0, 0, 32'h10C, 32'h9, 32'h0, 32'h0));
        check();
        set_fw(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0); #1;
        push("x0_guard", pk(0, 1, 1, 0, 2'b00, 5'd6, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        check();
        set_fw(0, 0, 0, 0, 0, 0);

        // Load to x3, then a consumer of x3 in ID
        set_id(1, 1, 0, 1, 2'b01, 3'd0, 3'd0, 32'h200, 32'h30, 32'h0, 32'h4, 5'd1, 5'd0, 5'd3);
        tick();
        set_id(1, 1, 0, 0, 2'b00, 3'd1, 3'd0, 32'h204, 32'h80, 32'h0, 32'h0, 5'd8, 5'd3, 5'd9); #1;
        push("load_use_stall", pk(1, 1, 1, 0, 2'b01, 5'd3, 0, 0, 32'h200, 32'h30, 32'h4, 32'h0));
        check();
        bus.hold = 1'b1;
        push("hold_with_stall", pk(1, 1, 1, 0, 2'b01, 5'd3, 0, 0, 32'h200, 32'h30, 32'h4, 32'h0));
        tick(); check();
        bus.hold = 1'b0;
        push("stall_bubble", pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tick(); check();
        set_fw(1, 5'd3, 32'hCAFE, 0, 0, 0);
        push("load_data_fwd", pk(0, 1, 1, 0, 2'b00, 5'd9, 3'd1, 0, 32'h204, 32'h80, 32'hCAFE, 32'hCAFE));
        tick(); check();
`else
        set_id(1, 0, 0, 0, 2'b00, 3'd0, 3'd0, 32'h10C, 32'h11, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0);
        push("latch_g", pk(0, 1, 0, 0, 2'b00, 5'd0, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        tick(); check();
        bus.id_valid = 1'b0;
        set_fw(1, 5'd5, 32'h1234, 0, 0, 0); #1;
        push("no_fwd_mem", pk(0, 1, 0, 0, 2'b00, 5'd0, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        check();
        set_fw(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0); #1;
        push("x0_guard", pk(0, 1, 0, 0, 2'b00, 5'd0, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        check();
        set_fw(0, 0, 0, 1, 5'd7, 32'h5);
        set_id(1, 1, 0, 0, 2'b00, 3'd3, 3'd0, 32'h300, 32'h77, 32'h99, 32'h0, 5'd7, 5'd9, 5'd4); #1;
        push("wb_stall", pk(1, 1, 0, 0, 2'b00, 5'd0, 0, 0, 32'h10C, 32'h11, 32'h0, 32'h0));
        check();
        for (int i = 0; i < 2; i++) begin
            push("wb_stall_bubble", pk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            tick(); check();
        end
        bus.wb_rf_we = 1'b0; #1;
        push("wb_release", pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        check();
        push("latch_after_wb", pk(0, 1, 1, 0, 2'b00, 5'd4, 3'd3, 0, 32'h300, 32'h77, 32'h99, 32'h99));
        tick(); check();
        bus.id_rs2 = 5'd4; #1;
        push("ex_stall", pk(1, 1, 1, 0, 2'b00, 5'd4, 3'd3, 0, 32'h300, 32'h77, 32'h99, 32'h99));
        check();
        bus.id_rs2 = 5'd10;
        set_fw(1, 5'd10, 32'h0, 0, 0, 0); #1;
        push("mem_stall", pk(1, 1, 1, 0, 2'b00, 5'd4, 3'd3, 0, 32'h300, 32'h77, 32'h99, 32'h99));
        check();
        bus.id_valid = 1'b0; #1;
        push("invalid_no_stall", pk(0, 1, 1, 0, 2'b00, 5'd4, 3'd3, 0, 32'h300, 32'h77, 32'h99, 32'h99));
        check();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage of the pipelined miniRV core; it sits directly upstream of the ALU and drives its `A`, `B`, `alu_op` and `br_op` inputs. It latches decoded instruction fields each cycle and selects forwarded operands from the MEM and WB stages. It detects load-use hazards and raises `stall`. It inserts bubbles on stall or branch flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into `ex_pc` on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`, `id_rf_we`, `id_ram_we`, `id_alub_sel`  in  1 each  decoded control bits; `alub_sel`=1 selects the immediate.
- `id_wd_sel`  in  2  writeback source; 2'b01 = load (DRAM).
- `id_alu_op`, `id_br_op`  in  3 each  ALU and branch opcodes; BR_NONE = 3'd0.
- `id_pc`, `id_rD1`, `id_rD2`, `id_imm`  in  32 each  decoded PC, register-file reads and immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `mem_rf_we`, `wb_rf_we`  in  1 each  write enables of the MEM and WB instructions.
- `mem_rd`, `wb_rd`  in  5 each  destinations of the MEM and WB instructions.
- `mem_wd`, `wb_wd`  in  32 each  write data of the MEM and WB instructions; `mem_wd` is valid for loads (combinational DRAM read).
- `hold`  in  1  global freeze (bus wait).
- `flush`  in  1  branch or jump taken; squashes the ID instruction.
- `stall`  out  1  holds PC and IF/ID.
- `ex_A`, `ex_B`, `ex_rs2_data`, `ex_pc`  out  32 each  ALU operands, forwarded store data and EX PC.
- `ex_alu_op`, `ex_br_op`  out  3 each  to the ALU.
- `ex_valid`, `ex_rf_we`, `ex_ram_we`  out  1 each  registered control.
- `ex_wd_sel`  out  2  registered writeback select.
- `ex_rd`  out  5  registered destination.

## Operation
- **Register update priority** (per rising edge): `flush` > `hold` > `stall` > normal load.
  - `flush` or `stall`: insert a bubble.
  - `hold`: keep all contents.
  - Normal: latch all `id_*` fields.
- **Bubble**: `valid`, `rf_we` and `ram_we` = 0; `alu_op` = 0; `br_op` = BR_NONE; `rd` = 0; data fields zeroed.
- **Load-use hazard**: `stall` is combinational and equals `ex_valid & ex_wd_sel==2'b01 & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid`.
- **Forwarding** (combinational, per source operand rs1 and rs2 using the latched `rs` index and latched `rD`):
  - If MEM matches (`mem_rf_we & mem_rd!=0 & mem_rd==rs`), use `mem_wd`.
  - Else if WB matches, use `wb_wd`.
  - Else use the latched `rD`.
  - MEM has priority over WB.
  - `rs`==0 never forwards.
- **Operand outputs**:
  - `ex_A` = forwarded rs1.
  - `ex_rs2_data` = forwarded rs2.
  - `ex_B` = `alub_sel` ? latched imm : forwarded rs2.
- **Width rules**: index compares are 5-bit; no arithmetic is performed.

## Timing
- Reset values: all registered outputs 0; `ex_br_op` = BR_NONE; `ex_pc` = `RESET_PC`.
- `stall` is 0 while `rst` is asserted.
- Reset mid-operation discards the EX instruction immediately (asynchronous).
- Latency: ID fields appear on `ex_*` one cycle after capture.
- Forwarded outputs are combinational from the current `mem_*` and `wb_*` inputs in the same cycle.
- A load-use stall lasts exactly one cycle: the bubble clears `ex_wd_sel`, so `stall` drops.
  - The dependent instruction then receives the load data via `mem_wd`.
- `stall` with `flush` in the same cycle: bubble; `stall` output is still driven; upstream applies its flush priority.
- `hold` with `stall`: contents kept; `stall` stays asserted.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding as described; only load-use stalls occur.
- Not defined:
  - No forwarding muxes; operands come only from the latched `rD` values.
  - `stall` asserts when `id_valid` is set and a nonzero `id_rs1`/`id_rs2` matches any of these destinations:
    - `ex_rd` (with `ex_rf_we`)
    - `mem_rd` (with `mem_rf_we`)
    - `wb_rd` (with `wb_rf_we`)
  - The register file does not bypass WB writes.

## Test plan
- Reset: assert `rst` mid-stream → all outputs 0, `ex_pc`=`RESET_PC`, `ex_br_op`=0, `stall`=0 immediately.
- MEM forward: EX `rs1`=5, `mem_rd`=5, `mem_rf_we`=1, `mem_wd`=32'h1234 → `ex_A`=32'h1234; with `wb_rd`=5 and `wb_wd`=32'h9 as well, still 32'h1234.
- x0 guard: `rs2`=0, `mem_rd`=0, `mem_rf_we`=1, `mem_wd`=32'hFFFF_FFFF → `ex_rs2_data`=0 (latched value).
- Load-use: load `rd`=3 in EX, ID `rs2`=3 → `stall`=1 for one cycle; next cycle `ex_valid`=0 and `stall`=0.
- `flush`=1 while `hold`=1 with a valid ID instruction → next cycle `ex_valid`=0, `ex_rf_we`=0, `ex_br_op`=0.
- Without `ID_EX_FORWARD_EN`: WB writes `rd`=7, ID reads `rs1`=7 → `stall`=1 until `wb_rf_we` deasserts.
